// File: rtl/feeder_pkg.sv
// Shared types and constants for the IFM window feeder.
package feeder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WGT,
        STREAM
    } state_e;

    // Kernel edge length; the window is KERNEL x KERNEL.
    localparam int unsigned KERNEL    = 3;
    localparam int unsigned WIN_ELEMS = KERNEL * KERNEL;

    // Flat window index of (row, col), row-major with 0 at the top-left.
    function automatic int unsigned win_idx(input int unsigned row, input int unsigned col);
        return row * KERNEL + col;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Enable-gated delay line: o_data is the word written DEPTH enables ago.
module line_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    logic [DEPTH-1:0][DATA_W-1:0] r_mem;

    // Shift one word in per enable; contents are never cleared.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_mem <= {r_mem[DEPTH-2:0], i_data};
        end
    end

    assign o_data = r_mem[DEPTH-1];

endmodule

// File: rtl/ifm_window_feeder.sv
// Loads a 3x3 kernel, then streams a raster-order frame and emits every
// fully-interior 3x3 pixel window to the PE array with a valid/ready handshake.
module ifm_window_feeder
    import feeder_pkg::*;
#(
    parameter int unsigned input_width = 8,
    parameter int unsigned PE_arr_size = 9,
    parameter int unsigned IMG_W       = 8,
    parameter int unsigned IMG_H       = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic                                    wgt_valid,
    output logic                                    wgt_ready,
    input  logic [input_width-1:0]                  wgt_data,
    input  logic                                    pix_valid,
    output logic                                    pix_ready,
    input  logic [input_width-1:0]                  pix_data,
    output logic [PE_arr_size-1:0][input_width-1:0] ifm_output,
    output logic [PE_arr_size-1:0][input_width-1:0] wgt_output,
    output logic                                    win_valid,
    input  logic                                    win_ready,
    output logic                                    frame_done,
    output logic                                    busy
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned KW = $clog2(PE_arr_size);

    state_e                                         r_state;
    logic [CW-1:0]                                  r_col;
    logic [RW-1:0]                                  r_row;
    logic [KW-1:0]                                  r_wgt_idx;
    logic                                           r_frame_done;
    logic                                           r_win_valid;
    logic [PE_arr_size-1:0][input_width-1:0]        r_ifm;
    logic [PE_arr_size-1:0][input_width-1:0]        r_wgt;
    logic [PE_arr_size-1:0][input_width-1:0]        w_ifm_next;
    logic [KERNEL-1:0][KERNEL-1:0][input_width-1:0] r_win;
    logic [KERNEL-1:0][KERNEL-1:0][input_width-1:0] w_win_next;
    logic [KERNEL-1:0][input_width-1:0]             w_col_in;
    logic [input_width-1:0]                         w_lb0_out;
    logic [input_width-1:0]                         w_lb1_out;
    logic                                           w_accept;
    logic                                           w_wgt_xfer;
    logic                                           w_col_last;
    logic                                           w_row_last;
    logic                                           w_win_hit;

    assign wgt_ready  = (r_state == LOAD_WGT);
    // A new pixel may only be taken when the window register is free or draining.
    assign pix_ready  = (r_state == STREAM) && (!r_win_valid || win_ready);
    assign busy       = (r_state != IDLE);
    assign ifm_output = r_ifm;
    assign wgt_output = r_wgt;
    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;

    assign w_accept   = pix_valid && pix_ready;
    assign w_wgt_xfer = wgt_valid && wgt_ready;
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));
    // Window exists only once two full rows and two columns of this row are in.
    assign w_win_hit  = w_accept && (r_row >= RW'(KERNEL - 1)) && (r_col >= CW'(KERNEL - 1));

    // Newest column entering the window: rows r-2, r-1, r from top to bottom.
    assign w_col_in = {pix_data, w_lb0_out, w_lb1_out};

    line_buffer #(
        .DATA_W (input_width),
        .DEPTH  (IMG_W)
    ) u_lb0 (
        .i_clk  (clk),
        .i_en   (w_accept),
        .i_data (pix_data),
        .o_data (w_lb0_out)
    );

    line_buffer #(
        .DATA_W (input_width),
        .DEPTH  (IMG_W)
    ) u_lb1 (
        .i_clk  (clk),
        .i_en   (w_accept),
        .i_data (w_lb0_out),
        .o_data (w_lb1_out)
    );

    // Shift the 3x3 window one column left and append the incoming column.
    always_comb begin
        w_win_next = r_win;
        for (int rr = 0; rr < KERNEL; rr++) begin
            for (int cc = 0; cc < KERNEL - 1; cc++) begin
                w_win_next[rr][cc] = r_win[rr][cc+1];
            end
            w_win_next[rr][KERNEL-1] = w_col_in[rr];
        end
    end

    // Flatten the shifted window into PE order (0 = top-left, row-major).
    always_comb begin
        w_ifm_next = '0;
        for (int rr = 0; rr < KERNEL; rr++) begin
            for (int cc = 0; cc < KERNEL; cc++) begin
                w_ifm_next[win_idx(rr, cc)] = w_win_next[rr][cc];
            end
        end
    end

    // Control FSM: kernel load, pixel counters and end-of-frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_wgt_idx    <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_frame_done <= 1'b0;
            r_wgt        <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= LOAD_WGT;
                        r_wgt_idx <= '0;
                    end
                end
                LOAD_WGT: begin
                    if (w_wgt_xfer) begin
                        r_wgt[r_wgt_idx] <= wgt_data;
                        if (r_wgt_idx == KW'(WIN_ELEMS - 1)) begin
                            r_wgt_idx <= '0;
                            r_state   <= STREAM;
                        end else begin
                            r_wgt_idx <= r_wgt_idx + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (w_accept) begin
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) begin
                                r_row        <= '0;
                                r_state      <= IDLE;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Window datapath and output handshake; a pending window is never overwritten
    // because pixels are only accepted when it is free or being consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win       <= '0;
            r_ifm       <= '0;
            r_win_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_win <= w_win_next;
            end
            if (w_win_hit) begin
                r_ifm       <= w_ifm_next;
                r_win_valid <= 1'b1;
            end else if (win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifm_window_feeder.sv
// Self-checking bench: a 4x4 instance for directed scenarios and an 8x8
// instance for randomised gaps, both scored against an index-based window model.
module tb_ifm_window_feeder;

    logic clk;
    logic rst;

    // 4x4 instance
    logic            start, wgt_valid, wgt_ready, pix_valid, pix_ready;
    logic [7:0]      wgt_data, pix_data;
    logic [8:0][7:0] ifm_output, wgt_output;
    logic            win_valid, win_ready, frame_done, busy;

    // 8x8 instance
    logic            b_start, b_wgt_valid, b_wgt_ready, b_pix_valid, b_pix_ready;
    logic [7:0]      b_wgt_data, b_pix_data;
    logic [8:0][7:0] b_ifm_output, b_wgt_output;
    logic            b_win_valid, b_win_ready, b_frame_done, b_busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  frame4[16];
    logic [7:0]  frame8[64];
    logic [71:0] exp4_q[$];
    logic [71:0] exp8_q[$];
    int          acc4 = 0, acc8 = 0;
    int          win_cnt4 = 0, win_cnt8 = 0;
    logic [71:0] first_win4, last_win4;

    int obs_done, obs_done_gap, obs_busy_bad, obs_stall_cycles, obs_stall_bad, obs_wgt_ready_bad;

    ifm_window_feeder #(
        .input_width (8),
        .PE_arr_size (9),
        .IMG_W       (4),
        .IMG_H       (4)
    ) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .wgt_valid  (wgt_valid),
        .wgt_ready  (wgt_ready),
        .wgt_data   (wgt_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .ifm_output (ifm_output),
        .wgt_output (wgt_output),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .frame_done (frame_done),
        .busy       (busy)
    );

    ifm_window_feeder #(
        .input_width (8),
        .PE_arr_size (9),
        .IMG_W       (8),
        .IMG_H       (8)
    ) dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (b_start),
        .wgt_valid  (b_wgt_valid),
        .wgt_ready  (b_wgt_ready),
        .wgt_data   (b_wgt_data),
        .pix_valid  (b_pix_valid),
        .pix_ready  (b_pix_ready),
        .pix_data   (b_pix_data),
        .ifm_output (b_ifm_output),
        .wgt_output (b_wgt_output),
        .win_valid  (b_win_valid),
        .win_ready  (b_win_ready),
        .frame_done (b_frame_done),
        .busy       (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard for the 4x4 instance: push on pixel accept, pop on window consume.
    always @(negedge clk) begin : mon4
        int r, c;
        logic [8:0][7:0] e;
        if (rst) begin
            acc4 = 0;
            exp4_q.delete();
        end else begin
            if (win_valid && win_ready) begin
                n_checks++;
                if (exp4_q.size() == 0) begin
                    $display("FAIL win4_unexpected: got %h, required no window", ifm_output);
                end else begin
                    e = exp4_q.pop_front();
                    if (ifm_output !== e) $display("FAIL win4_data: got %h, required %h", ifm_output, e);
                    else n_pass++;
                end
                if (win_cnt4 == 0) first_win4 = ifm_output;
                last_win4 = ifm_output;
                win_cnt4++;
            end
            if (pix_valid && pix_ready) begin
                r = acc4 / 4;
                c = acc4 % 4;
                if (r >= 2 && c >= 2) begin
                    for (int i = 0; i < 9; i++) e[i] = frame4[(r - 2 + i / 3) * 4 + (c - 2 + i % 3)];
                    exp4_q.push_back(e);
                end
                acc4 = (acc4 + 1) % 16;
            end
        end
    end

    // Scoreboard for the 8x8 instance.
    always @(negedge clk) begin : mon8
        int r, c;
        logic [8:0][7:0] e;
        if (rst) begin
            acc8 = 0;
            exp8_q.delete();
        end else begin
            if (b_win_valid && b_win_ready) begin
                n_checks++;
                if (exp8_q.size() == 0) begin
                    $display("FAIL win8_unexpected: got %h, required no window", b_ifm_output);
                end else begin
                    e = exp8_q.pop_front();
                    if (b_ifm_output !== e) $display("FAIL win8_data: got %h, required %h", b_ifm_output, e);
                    else n_pass++;
                end
                win_cnt8++;
            end
            if (b_pix_valid && b_pix_ready) begin
                r = acc8 / 8;
                c = acc8 % 8;
                if (r >= 2 && c >= 2) begin
                    for (int i = 0; i < 9; i++) e[i] = frame8[(r - 2 + i / 3) * 8 + (c - 2 + i % 3)];
                    exp8_q.push_back(e);
                end
                acc8 = (acc8 + 1) % 64;
            end
        end
    end

    // Start a frame on the 4x4 instance and feed weights base..base+8.
    task automatic load_wgts4(input int base);
        int  k = 0, cyc = 0;
        bit  acc;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wgt_valid = 1'b1;
        wgt_data  = 8'(base);
        while (k < 9 && cyc < 100) begin
            @(negedge clk);
            acc = wgt_valid && wgt_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) k++;
            wgt_valid = (k < 9);
            wgt_data  = 8'(base + k);
        end
        wgt_valid = 1'b0;
        n_checks++;
        if (k != 9) $display("FAIL wgt4_load_timeout: got %0d weights, required 9", k); else n_pass++;
    endtask

    // Stream n_pix pixels of frame4 into the 4x4 instance, recording observations.
    task automatic run_frame4(input int n_pix, input bit stall, input bit poke);
        int              idx = 0, cyc = 0, after = 0;
        bit              acc, poked = 1'b0;
        logic [8:0][7:0] held = '0;
        obs_done = 0; obs_done_gap = 0; obs_busy_bad = 0;
        obs_stall_cycles = 0; obs_stall_bad = 0; obs_wgt_ready_bad = 0;
        win_ready = !stall;
        pix_valid = 1'b1;
        pix_data  = frame4[0];
        while ((idx < n_pix || after < 5) && cyc < 300) begin
            @(negedge clk);
            if (frame_done) begin
                obs_done++;
                obs_done_gap = after;
                if (busy) obs_busy_bad++;
            end
            if (wgt_ready) obs_wgt_ready_bad++;
            if (stall && win_valid && !win_ready) begin
                if (obs_stall_cycles == 0) held = ifm_output;
                obs_stall_cycles++;
                if (pix_ready || ifm_output !== held) obs_stall_bad++;
            end
            acc = pix_valid && pix_ready;
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (after > 0) after++;
            if (acc) begin
                idx++;
                if (idx == n_pix) after = 1;
            end
            pix_valid = (idx < n_pix);
            pix_data  = frame4[idx % 16];
            if (stall && obs_stall_cycles >= 5) win_ready = 1'b1;
            if (poke && !poked && idx == 8) begin
                start = 1'b1;
                poked = 1'b1;
            end
        end
        pix_valid = 1'b0;
        win_ready = 1'b1;
        start     = 1'b0;
        n_checks++;
        if (idx != n_pix) $display("FAIL run4_timeout: got %0d pixels, required %0d", idx, n_pix); else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (wgt_ready !== 1'b0) $display("FAIL reset_wgt_ready: got %b, required 0", wgt_ready); else n_pass++;
        n_checks++; if (pix_ready !== 1'b0) $display("FAIL reset_pix_ready: got %b, required 0", pix_ready); else n_pass++;
        n_checks++; if (win_valid !== 1'b0) $display("FAIL reset_win_valid: got %b, required 0", win_valid); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b, required 0", frame_done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else n_pass++;
        n_checks++; if (ifm_output !== '0) $display("FAIL reset_ifm: got %h, required 0", ifm_output); else n_pass++;
        n_checks++; if (wgt_output !== '0) $display("FAIL reset_wgt: got %h, required 0", wgt_output); else n_pass++;
        n_checks++; if (b_busy !== 1'b0) $display("FAIL reset_busy8: got %b, required 0", b_busy); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic_frame();
        int              exp_first[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        int              exp_last[9]  = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        logic [8:0][7:0] ef, el, ew;
        for (int i = 0; i < 16; i++) frame4[i] = 8'(i);
        for (int i = 0; i < 9; i++) begin
            ef[i] = 8'(exp_first[i]);
            el[i] = 8'(exp_last[i]);
            ew[i] = 8'(i + 1);
        end
        load_wgts4(1);
        n_checks++; if (wgt_output !== ew) $display("FAIL basic_wgt: got %h, required %h", wgt_output, ew); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy_stream: got %b, required 1", busy); else n_pass++;
        win_cnt4 = 0;
        run_frame4(16, 1'b0, 1'b0);
        n_checks++; if (win_cnt4 != 4) $display("FAIL basic_win_count: got %0d, required 4", win_cnt4); else n_pass++;
        n_checks++; if (first_win4 !== ef) $display("FAIL basic_first_win: got %h, required %h", first_win4, ef); else n_pass++;
        n_checks++; if (last_win4 !== el) $display("FAIL basic_last_win: got %h, required %h", last_win4, el); else n_pass++;
        n_checks++; if (obs_done != 1) $display("FAIL basic_done_count: got %0d, required 1", obs_done); else n_pass++;
        n_checks++; if (obs_done_gap != 1) $display("FAIL basic_done_latency: got %0d, required 1", obs_done_gap); else n_pass++;
        n_checks++; if (obs_busy_bad != 0) $display("FAIL basic_busy_at_done: got %0d, required 0", obs_busy_bad); else n_pass++;
        n_checks++; if (exp4_q.size() != 0) $display("FAIL basic_pending: got %0d, required 0", exp4_q.size()); else n_pass++;
        n_checks++; if (wgt_output !== ew) $display("FAIL basic_wgt_held: got %h, required %h", wgt_output, ew); else n_pass++;
    endtask

    task automatic test_backpressure();
        load_wgts4(1);
        win_cnt4 = 0;
        run_frame4(16, 1'b1, 1'b0);
        n_checks++; if (obs_stall_cycles != 5) $display("FAIL bp_stall_cycles: got %0d, required 5", obs_stall_cycles); else n_pass++;
        n_checks++; if (obs_stall_bad != 0) $display("FAIL bp_stall_hold: got %0d, required 0", obs_stall_bad); else n_pass++;
        n_checks++; if (win_cnt4 != 4) $display("FAIL bp_win_count: got %0d, required 4", win_cnt4); else n_pass++;
        n_checks++; if (exp4_q.size() != 0) $display("FAIL bp_pending: got %0d, required 0", exp4_q.size()); else n_pass++;
        n_checks++; if (obs_done != 1) $display("FAIL bp_done_count: got %0d, required 1", obs_done); else n_pass++;
    endtask

    task automatic test_start_ignored();
        logic [8:0][7:0] ew;
        for (int i = 0; i < 9; i++) ew[i] = 8'(i + 1);
        load_wgts4(1);
        win_cnt4 = 0;
        run_frame4(16, 1'b0, 1'b1);
        n_checks++; if (obs_wgt_ready_bad != 0) $display("FAIL start_wgt_ready: got %0d, required 0", obs_wgt_ready_bad); else n_pass++;
        n_checks++; if (win_cnt4 != 4) $display("FAIL start_win_count: got %0d, required 4", win_cnt4); else n_pass++;
        n_checks++; if (obs_done != 1) $display("FAIL start_done_count: got %0d, required 1", obs_done); else n_pass++;
        n_checks++; if (wgt_output !== ew) $display("FAIL start_wgt_held: got %h, required %h", wgt_output, ew); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int              exp_first[9] = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
        logic [8:0][7:0] ef;
        for (int i = 0; i < 9; i++) ef[i] = 8'(exp_first[i]);
        for (int i = 0; i < 16; i++) frame4[i] = 8'(i);
        load_wgts4(1);
        run_frame4(7, 1'b0, 1'b0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b, required 0", busy); else n_pass++;
        n_checks++; if (win_valid !== 1'b0) $display("FAIL rst_mid_win_valid: got %b, required 0", win_valid); else n_pass++;
        for (int i = 0; i < 16; i++) frame4[i] = 8'(100 + i);
        load_wgts4(1);
        win_cnt4 = 0;
        run_frame4(16, 1'b0, 1'b0);
        n_checks++; if (first_win4 !== ef) $display("FAIL rst_mid_first_win: got %h, required %h", first_win4, ef); else n_pass++;
        n_checks++; if (win_cnt4 != 4) $display("FAIL rst_mid_win_count: got %0d, required 4", win_cnt4); else n_pass++;
        n_checks++; if (obs_done != 1) $display("FAIL rst_mid_done_count: got %0d, required 1", obs_done); else n_pass++;
    endtask

    task automatic test_random_8x8();
        int              k = 0, idx = 0, cyc = 0, done_cnt = 0;
        bit              acc;
        logic [8:0][7:0] ew;
        for (int i = 0; i < 64; i++) frame8[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 9; i++) ew[i] = 8'($urandom_range(0, 255));
        @(posedge clk); #1; b_start = 1'b1;
        @(posedge clk); #1; b_start = 1'b0;
        b_wgt_valid = 1'b1;
        b_wgt_data  = ew[0];
        while (k < 9 && cyc < 200) begin
            @(negedge clk);
            acc = b_wgt_valid && b_wgt_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) k++;
            b_wgt_valid = (k < 9) && ($urandom_range(0, 3) != 0);
            b_wgt_data  = ew[k % 9];
        end
        b_wgt_valid = 1'b0;
        n_checks++; if (b_wgt_output !== ew) $display("FAIL rand_wgt: got %h, required %h", b_wgt_output, ew); else n_pass++;
        win_cnt8 = 0;
        cyc = 0;
        b_pix_valid = ($urandom_range(0, 3) != 0);
        b_pix_data  = frame8[0];
        while ((idx < 64 || exp8_q.size() != 0 || b_win_valid) && cyc < 3000) begin
            @(negedge clk);
            if (b_frame_done) done_cnt++;
            acc = b_pix_valid && b_pix_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) idx++;
            b_pix_valid = (idx < 64) && ($urandom_range(0, 3) != 0);
            b_pix_data  = frame8[idx % 64];
            b_win_ready = ($urandom_range(0, 2) != 0);
        end
        b_pix_valid = 1'b0;
        b_win_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (b_frame_done) done_cnt++;
        end
        n_checks++; if (idx != 64) $display("FAIL rand_timeout: got %0d pixels, required 64", idx); else n_pass++;
        n_checks++; if (win_cnt8 != 36) $display("FAIL rand_win_count: got %0d, required 36", win_cnt8); else n_pass++;
        n_checks++; if (exp8_q.size() != 0) $display("FAIL rand_pending: got %0d, required 0", exp8_q.size()); else n_pass++;
        n_checks++; if (done_cnt != 1) $display("FAIL rand_done_count: got %0d, required 1", done_cnt); else n_pass++;
        n_checks++; if (b_busy !== 1'b0) $display("FAIL rand_busy_end: got %b, required 0", b_busy); else n_pass++;
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0; wgt_valid   = 1'b0; wgt_data   = '0;
        pix_valid   = 1'b0; pix_data    = '0;   win_ready  = 1'b1;
        b_start     = 1'b0; b_wgt_valid = 1'b0; b_wgt_data = '0;
        b_pix_valid = 1'b0; b_pix_data  = '0;   b_win_ready = 1'b1;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_frame();
        test_random_8x8();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifm_window_feeder.md
IFM_WINDOW_FEEDER -- requirements
Module: ifm_window_feeder

Interface
REQ-001 SHALL have parameter input_width, default 8, pixel/weight bit width.
REQ-002 SHALL have parameter PE_arr_size, default 9, window elements (3x3 kernel, fixed).
REQ-003 SHALL have parameters IMG_W, default 8, and IMG_H, default 8: frame width/height in pixels, each 3..64.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins weight load for a new frame.
REQ-007 wgt_valid / wgt_ready  in / out  1 / 1  weight-stream handshake.
REQ-008 wgt_data  in  input_width  weight word, row-major kernel order.
REQ-009 pix_valid / pix_ready  in / out  1 / 1  pixel-stream handshake.
REQ-010 pix_data  in  input_width  IFM pixel, raster order.
REQ-011 ifm_output  out  input_width x PE_arr_size  current 3x3 window to PE array.
REQ-012 wgt_output  out  input_width x PE_arr_size  held kernel to PE array.
REQ-013 win_valid / win_ready  out / in  1 / 1  window handshake.
REQ-014 frame_done  out  1  one-cycle pulse after last pixel of frame accepted.
REQ-015 busy  out  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> LOAD_WGT (on start) -> STREAM (after 9th weight) -> IDLE (after pixel IMG_W*IMG_H-1 accepted).
REQ-017 start outside IDLE SHALL be ignored.
REQ-018 wgt_ready SHALL be high only in LOAD_WGT; transfer on wgt_valid&&wgt_ready writes wgt_output[k], k=0..8 incrementing.
REQ-019 wgt_output SHALL hold its value from load completion until the next LOAD_WGT write.
REQ-020 pix_ready SHALL equal (state==STREAM) && (!win_valid || win_ready).
REQ-021 Accepted pixels SHALL update column counter c (0..IMG_W-1) and row counter r (0..IMG_H-1); c wraps to 0 and r increments at row end.
REQ-022 Two row line buffers (depth IMG_W) plus a 3x3 shift window SHALL hold rows r-2, r-1, r.
REQ-023 On acceptance of pixel (r,c) with r>=2 and c>=2, ifm_output[i] SHALL register pixel (r-2+i/3, c-2+i%3), i=0 top-left, and win_valid SHALL rise next cycle (latency 1).
REQ-024 Pixels with r<2 or c<2 SHALL produce no window; the window SHALL not straddle row boundaries (no wrap-around windows).
REQ-025 Frame SHALL yield exactly (IMG_W-2)*(IMG_H-2) windows.
REQ-026 win_valid SHALL stay high with ifm_output stable until win_ready; win_ready with no new window clears win_valid; consume and new window in the same cycle keeps win_valid high with new data.
REQ-027 frame_done SHALL pulse the cycle after the last pixel is accepted; counters SHALL return to 0; the final window SHALL still complete its handshake in IDLE.
REQ-028 Arithmetic: none; data passes unmodified, unsigned bit-exact.

Reset
REQ-029 On rst: state IDLE, counters 0, win_valid 0, frame_done 0, wgt_ready 0, pix_ready 0, ifm_output and wgt_output all zero.
REQ-030 rst mid-frame SHALL abandon the frame; line buffer contents need not be cleared but SHALL not produce windows before r>=2 of the next frame.

Structure
REQ-031 Shared package feeder_pkg SHALL hold the state enum (IDLE, LOAD_WGT, STREAM) and the kernel-size constant 3.
REQ-032 One sub-module line_buffer (input_width wide, IMG_W deep, enable-gated delay line) SHALL be instantiated twice.

Verification
REQ-033 IMG_W=IMG_H=4, weights 1..9, pixels 0..15, win_ready=1 -> wgt_output={1..9}; 4 windows, first {0,1,2,4,5,6,8,9,10}, last {5,6,7,9,10,11,13,14,15}.
REQ-034 Same frame, win_ready held low 5 cycles at first window -> pix_ready low, ifm_output unchanged, no window lost or duplicated.
REQ-035 frame_done pulses exactly once, one cycle after pixel 15 accepted; busy falls same cycle.
REQ-036 start pulsed during STREAM -> no effect; wgt_ready remains 0.
REQ-037 rst asserted after pixel 6, new frame 100..115 -> first window {100,101,102,104,105,106,108,109,110}, no stale data.
REQ-038 Random pix_valid/win_ready gaps, 8x8 frame -> 36 windows matching golden model.
